// File: rtl/note_detector.sv
// note_detector: measures the half-period of an incoming square-wave tone and
// decodes which of the 8 scale notes (C4..C5) is sounding, after STABLE_CNT
// consecutive matching half-periods.
// Optional feature: define NOTE_DET_PERIOD_OUT_EN to expose the PERIOD port.
// NOM_SHIFT right-shifts the nominal half-period table (0 = 100 MHz audio rates).
module note_detector #(
   parameter int unsigned TOL        = 2000,
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned TIMEOUT    = 262143,
   parameter int unsigned NOM_SHIFT  = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TONE_IN,
   output logic [3:0]  NOTE_CODE,
   output logic        NOTE_VALID,
   output logic        NOTE_CHANGE
`ifdef NOTE_DET_PERIOD_OUT_EN
   ,
   output logic [17:0] PERIOD
`endif
);

   localparam int unsigned CNT_W   = 18;
   localparam int unsigned CODE_W  = 4;
   localparam int unsigned MATCH_W = 4;
   localparam int unsigned N_NOTES = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, MEAS, ACQ, LOCK} state_t;

   logic [2:0]         sync_q;
   logic               edge_det;
   logic [CNT_W-1:0]   cnt;
   logic [CODE_W-1:0]  h_class;
   state_t             state, state_nx;
   logic [CODE_W-1:0]  cand, cand_nx;
   logic [MATCH_W-1:0] match, match_nx;
   logic               lock_now;

   // Nominal half-period (in CLK cycles) of each note code
   function automatic logic [CNT_W-1:0] nominal(input logic [CODE_W-1:0] code);
      logic [CNT_W-1:0] n;
      case (code)
         4'd1:    n = 18'd191110;
         4'd2:    n = 18'd170266;
         4'd3:    n = 18'd151686;
         4'd4:    n = 18'd143173;
         4'd5:    n = 18'd127552;
         4'd6:    n = 18'd113637;
         4'd7:    n = 18'd101215;
         4'd8:    n = 18'd95603;
         default: n = '0;
      endcase
      return n >> NOM_SHIFT;
   endfunction

   // True when h lies within +/-TOL of nom
   function automatic logic in_window(input logic [CNT_W-1:0] h,
                                      input logic [CNT_W-1:0] nom);
      logic [CNT_W-1:0] d;
      d = (h >= nom) ? (h - nom) : (nom - h);
      return 32'(d) <= TOL;
   endfunction

   // Second flop of the synchronizer against its delayed copy flags both edges
   assign edge_det = sync_q[2] ^ sync_q[1];

   // Classify the running count; scanning downwards lets the lowest code win overlaps
   always_comb begin
      h_class = '0;
      for (int k = N_NOTES; k >= 1; k--) begin
         if (in_window(cnt, nominal(CODE_W'(k)))) h_class = CODE_W'(k);
      end
   end

   // Acquisition decision applied when an edge is detected
   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      match_nx = match;
      lock_now = 1'b0;
      case (state)
         IDLE: state_nx = MEAS;
         MEAS, LOCK: begin
            if (h_class == '0) begin
               state_nx = MEAS;
               match_nx = '0;
            end else if (state == LOCK && h_class == NOTE_CODE) begin
               state_nx = LOCK;
            end else begin
               state_nx = ACQ;
               cand_nx  = h_class;
               match_nx = MATCH_W'(1);
            end
         end
         ACQ: begin
            if (h_class == cand && h_class != '0) begin
               match_nx = match + MATCH_W'(1);
            end else if (h_class != '0) begin
               cand_nx  = h_class;
               match_nx = MATCH_W'(1);
            end else begin
               state_nx = MEAS;
               cand_nx  = '0;
               match_nx = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (state_nx == ACQ && 32'(match_nx) >= STABLE_CNT) begin
         state_nx = LOCK;
         lock_now = 1'b1;
      end
   end

   // Synchronizer, saturating half-period counter, FSM state and registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_q      <= '0;
         cnt         <= '0;
         state       <= IDLE;
         cand        <= '0;
         match       <= '0;
         NOTE_CODE   <= '0;
         NOTE_VALID  <= 1'b0;
         NOTE_CHANGE <= 1'b0;
      end else begin
         sync_q      <= {sync_q[1:0], TONE_IN};
         NOTE_CHANGE <= 1'b0;
         if (edge_det) begin
            cnt   <= CNT_W'(1);
            state <= state_nx;
            cand  <= cand_nx;
            match <= match_nx;
            if (lock_now) begin
               NOTE_CODE   <= cand_nx;
               NOTE_VALID  <= 1'b1;
               NOTE_CHANGE <= !NOTE_VALID || (NOTE_CODE != cand_nx);
            end
         end else if (cnt == CNT_PRE) begin
            cnt         <= CNT_MAX;
            state       <= IDLE;
            cand        <= '0;
            match       <= '0;
            NOTE_CODE   <= '0;
            NOTE_VALID  <= 1'b0;
            NOTE_CHANGE <= NOTE_VALID;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef NOTE_DET_PERIOD_OUT_EN
   // Last measured half-period; the saturated count is loaded on silence
   always_ff @(posedge CLK) begin
      if (RESET) begin
         PERIOD <= '0;
      end else if (edge_det) begin
         PERIOD <= cnt;
      end else if (cnt == CNT_PRE) begin
         PERIOD <= CNT_MAX;
      end
   end
`endif

endmodule
